// File: rtl/regfile_wb.sv
// Writeback-side GPR file: one-cycle pending-write stage in front of the array,
// two combinational read ports that bypass both the live request and the pending write.
module regfile_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [DATA_W-1:0] busA,
  output logic [DATA_W-1:0] busB,
  input  logic              wbEn,
  input  logic [ADDR_W-1:0] wbAddr,
  input  logic [DATA_W-1:0] wbData,
  input  logic              wbFlagEn,
  input  logic              zf,
  input  logic              of,
  input  logic              cf,
  output logic [2:0]        flags,
  output logic              pendValid
);

  logic [DATA_W-1:0] regs [NREG];
  logic [ADDR_W-1:0] pendAddr;
  logic [DATA_W-1:0] pendData;
  logic              wbAccept;

  // r0 and out-of-range destinations never reach the pending stage
  assign wbAccept = wbEn && (wbAddr != '0) && (int'(wbAddr) < NREG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      pendValid <= 1'b0;
      pendAddr  <= '0;
      pendData  <= '0;
      flags     <= 3'b000;
    end else begin
      if (pendValid) regs[pendAddr] <= pendData;
      pendValid <= wbAccept;
      if (wbAccept) begin
        pendAddr <= wbAddr;
        pendData <= wbData;
      end
      if (wbFlagEn) flags <= {cf, of, zf};
    end
  end

  // Newest data wins: live request, then pending write, then the array
  always_comb begin
    busA = '0;
    if ((rs1 != '0) && (int'(rs1) < NREG)) begin
      if (wbEn && (wbAddr == rs1))              busA = wbData;
      else if (pendValid && (pendAddr == rs1))  busA = pendData;
      else                                      busA = regs[rs1];
    end
  end

  always_comb begin
    busB = '0;
    if ((rs2 != '0) && (int'(rs2) < NREG)) begin
      if (wbEn && (wbAddr == rs2))              busB = wbData;
      else if (pendValid && (pendAddr == rs2))  busB = pendData;
      else                                      busB = regs[rs2];
    end
  end

endmodule

// File: tb/tb_regfile_wb.sv
// Bench for regfile_wb: architectural model (last accepted write per register,
// visible immediately) checked every cycle, plus directed literal checks.
module tb_regfile_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1, rs2, wbAddr;
  logic [31:0] wbData;
  logic        wbEn, wbFlagEn, zf, of, cf;
  logic [31:0] busA, busB;
  logic [2:0]  flags;
  logic        pendValid;

  int nChecks = 0;
  int nPass   = 0;

  regfile_wb dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .busA(busA), .busB(busB),
    .wbEn(wbEn), .wbAddr(wbAddr), .wbData(wbData), .wbFlagEn(wbFlagEn),
    .zf(zf), .of(of), .cf(cf), .flags(flags), .pendValid(pendValid)
  );

  always #5 clk = ~clk;

  // Architectural view: a register holds its most recent accepted write;
  // pendValid just says the previous edge accepted a write.
  logic [31:0] mArr [32];
  logic        mPend;
  logic [2:0]  mFlags;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mArr[i] <= 32'd0;
      mPend  <= 1'b0;
      mFlags <= 3'b000;
    end else begin
      if (wbEn && wbAddr != 5'd0) mArr[wbAddr] <= wbData;
      mPend <= wbEn && (wbAddr != 5'd0);
      if (wbFlagEn) mFlags <= {cf, of, zf};
    end
  end

  function automatic logic [31:0] expRead(input logic [4:0] rs);
    if (rs == 5'd0)                 return 32'd0;
    if (wbEn && wbAddr == rs)       return wbData;
    return mArr[rs];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    chk("model busA", busA, expRead(rs1));
    chk("model busB", busB, expRead(rs2));
    chk("model pendValid", {31'd0, pendValid}, {31'd0, mPend});
    chk("model flags", {29'd0, flags}, {29'd0, mFlags});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rs1 = 0; rs2 = 0; wbAddr = 0; wbData = 0;
    wbEn = 0; wbFlagEn = 0; zf = 0; of = 0; cf = 0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("reset pendValid", {31'd0, pendValid}, 32'd0);
    chk("reset flags", {29'd0, flags}, 32'd0);

    // single write r5=45, bypass then pending then array
    step();
    wbEn = 1; wbAddr = 5; wbData = 45; rs1 = 5;
    #1 chk("r5 same-cycle busA", busA, 32'd45);
    chk("r5 pend before edge", {31'd0, pendValid}, 32'd0);
    step();
    wbEn = 0;
    #1 chk("r5 pendValid edge1", {31'd0, pendValid}, 32'd1);
    chk("r5 busA edge1", busA, 32'd45);
    step();
    #1 chk("r5 pendValid edge2", {31'd0, pendValid}, 32'd0);
    chk("r5 busA array", busA, 32'd45);

    // write to r0 ignored
    wbEn = 1; wbAddr = 0; wbData = 123; rs1 = 0;
    #1 chk("r0 busA", busA, 32'd0);
    step();
    #1 chk("r0 pendValid", {31'd0, pendValid}, 32'd0);
    chk("r0 busA after", busA, 32'd0);
    wbEn = 0;

    // back-to-back r7=90 then r7=6
    step();
    wbEn = 1; wbAddr = 7; wbData = 90; rs1 = 7; rs2 = 7;
    #1 chk("r7 busA 90", busA, 32'd90);
    chk("r7 busB 90", busB, 32'd90);
    step();
    wbData = 6;
    #1 chk("r7 busA 6", busA, 32'd6);
    chk("r7 busB 6", busB, 32'd6);
    step();
    wbEn = 0;
    #1 chk("r7 busA pend 6", busA, 32'd6);
    step(); step();
    chk("r7 busA drained", busA, 32'd6);
    chk("r7 busB drained", busB, 32'd6);

    // flags capture and hold, also with a write to r0
    wbFlagEn = 1; zf = 1; of = 0; cf = 1;
    step();
    wbFlagEn = 0; zf = 0; of = 1; cf = 0;
    #1 chk("flags 101", {29'd0, flags}, 32'd5);
    step();
    #1 chk("flags hold 101", {29'd0, flags}, 32'd5);
    wbFlagEn = 1; wbEn = 1; wbAddr = 0; wbData = 77;
    step();
    wbFlagEn = 0; wbEn = 0;
    #1 chk("flags 010 on r0 write", {29'd0, flags}, 32'd2);

    // burst of writes to every register, then read back in pairs
    for (int i = 1; i < 32; i++) begin
      wbEn = 1; wbAddr = 5'(i); wbData = 32'h1000_0000 + 32'(i) * 32'h0101;
      step();
    end
    wbEn = 0;
    step(); step();
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      step();
    end
    rs1 = 12; rs2 = 31;
    #1 chk("r12 literal", busA, 32'h1000_0C0C);
    chk("r31 literal", busB, 32'h1000_1F1F);

    // reset while a write is pending
    step();
    wbEn = 1; wbAddr = 3; wbData = 8; rs1 = 3; rs2 = 3;
    step();
    wbEn = 0;
    #1 chk("r3 pend set", {31'd0, pendValid}, 32'd1);
    rst = 1;
    #1 chk("async pendValid", {31'd0, pendValid}, 32'd0);
    chk("async flags", {29'd0, flags}, 32'd0);
    chk("async busA r3", busA, 32'd0);
    chk("async busB r3", busB, 32'd0);
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      #1;
      if (busA !== 32'd0 || busB !== 32'd0) chk("reset read zero", busA | busB, 32'd0);
    end
    @(posedge clk);
    #1 rst = 0;
    rs1 = 3; rs2 = 7;
    step(); step();
    chk("r3 after reset", busA, 32'd0);
    chk("r7 after reset", busB, 32'd0);
    chk("pendValid after reset", {31'd0, pendValid}, 32'd0);

    step(); step();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
